// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential 16x16 multiplier among NREQ requesters.
// Optional: define MULT_ARB_TIMEOUT_EN to abort multiplies that wait TIMEOUT cycles.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*W-1:0]          rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [W-1:0]            mul_a,
  output logic [W-1:0]            mul_b,
  output logic                    mul_init,
  input  logic                    mul_done,
  input  logic [2*W-1:0]          mul_pp
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, START, WAIT_LO, WAIT_HI, RESP} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] last_grant, id, winner;
  logic           found, done_hit, expire;
  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];

  generate
    if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mult_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  // Search upward from the requester after the last winner, wrapping at NREQ.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign done_hit = (state == WAIT_HI) && mul_done;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == START) begin
      wait_cnt <= '0;
    end else if (state == WAIT_LO || state == WAIT_HI) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A real completion in the same cycle as the deadline still wins.
  assign expire = (state == WAIT_LO || state == WAIT_HI) && !done_hit &&
                  (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (done_hit) begin
      rsp_err <= 1'b0;
    end else if (expire) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_next        = START;
        end
      end
      START:   state_next = WAIT_LO;
      // Waiting for done to drop discards a level left over from the previous product.
      WAIT_LO: if (!mul_done) state_next = WAIT_HI;
      WAIT_HI: if (mul_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (expire) begin
      state_next = RESP;
    end
  end

  assign mul_init  = (state == START) || (state == WAIT_LO);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
      id         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      if (state == IDLE && found) begin
        mul_a      <= a_arr[winner];
        mul_b      <= b_arr[winner];
        id         <= winner;
        last_grant <= winner;
      end
      if (done_hit) begin
        rsp_data <= mul_pp;
        rsp_id   <= id;
      end else if (expire) begin
        rsp_data <= '0;
        rsp_id   <= id;
      end
    end
  end

endmodule
